// File: rtl/match_pkg.sv
// Shared encodings for the match sequencer: FSM states, winner codes,
// button bit positions and the saturating round-win increment.
package match_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT    = 3'd0,
    ST_INTRO      = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_KO         = 3'd3,
    ST_MATCH_OVER = 3'd4
  } match_state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_ATTACK = 0;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/match_controller_frame_tick_gen.sv
// Free-running frame divider: one-clk registered strobe every FRAME_DIV clocks,
// first strobe FRAME_DIV clocks after reset release.
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic reset_n,
  output logic frame_tick
);

  localparam int W = $clog2(FRAME_DIV);
  localparam logic [W-1:0] LAST = W'(FRAME_DIV - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (div_cnt == LAST);
      div_cnt    <= (div_cnt == LAST) ? '0 : div_cnt + ONE;
    end
  end

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer above the two player FSMs: paces frames, holds players
// in reset between rounds, gates buttons, scores KOs and declares the winner.
module match_controller
  import match_pkg::*;
#(
  parameter int FRAME_DIV     = 833333,
  parameter int INTRO_FRAMES  = 180,
  parameter int KO_FRAMES     = 120,
  parameter int ROUNDS_TO_WIN = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       p1_died,
  input  logic       p2_died,
  input  logic [2:0] p1_buttons_in,
  input  logic [2:0] p2_buttons_in,
  output logic       frame_tick,
  output logic [2:0] p1_buttons,
  output logic [2:0] p2_buttons,
  output logic       player_rst,
  output logic [2:0] match_state,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [1:0] winner
);

  localparam int MAX_FRAMES = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
  localparam int CW = $clog2(MAX_FRAMES) + 1;
  localparam logic [CW-1:0] INTRO_LAST = CW'(INTRO_FRAMES - 1);
  localparam logic [CW-1:0] KO_LAST    = CW'(KO_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [1:0]    WIN_TARGET = 2'(ROUNDS_TO_WIN);

  match_state_t  state;
  logic [CW-1:0] frame_cnt;
  logic          start_q;
  logic          fight_en;
  logic          start_edge;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick)
  );

  assign start_edge  = start & ~start_q;
  assign match_state = state;

  // Gating stays combinational so the player FSMs see buttons without extra delay.
  assign p1_buttons = p1_buttons_in & {3{fight_en}};
  assign p2_buttons = p2_buttons_in & {3{fight_en}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_ATTRACT;
      frame_cnt  <= '0;
      start_q    <= 1'b0;
      fight_en   <= 1'b0;
      player_rst <= 1'b1;
      p1_wins    <= 2'd0;
      p2_wins    <= 2'd0;
      winner     <= WIN_NONE;
    end else begin
      start_q <= start;
      case (state)
        ST_ATTRACT, ST_MATCH_OVER: begin
          if (start_edge) begin
            state      <= ST_INTRO;
            frame_cnt  <= '0;
            player_rst <= 1'b1;
            p1_wins    <= 2'd0;
            p2_wins    <= 2'd0;
            winner     <= WIN_NONE;
          end
        end
        ST_INTRO: begin
          if (frame_tick) begin
            if (frame_cnt == INTRO_LAST) begin
              state      <= ST_FIGHT;
              frame_cnt  <= '0;
              player_rst <= 1'b0;
              fight_en   <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + CNT_ONE;
            end
          end
        end
        ST_FIGHT: begin
          // Only the first died cycle scores; KO ignores later flags.
          if (p1_died || p2_died) begin
            state     <= ST_KO;
            frame_cnt <= '0;
            fight_en  <= 1'b0;
            if (p1_died && !p2_died) p2_wins <= sat_inc(p2_wins);
            if (p2_died && !p1_died) p1_wins <= sat_inc(p1_wins);
          end
        end
        ST_KO: begin
          if (frame_tick) begin
            if (frame_cnt == KO_LAST) begin
              frame_cnt  <= '0;
              player_rst <= 1'b1;
              if (p1_wins == WIN_TARGET) begin
                state  <= ST_MATCH_OVER;
                winner <= WIN_P1;
              end else if (p2_wins == WIN_TARGET) begin
                state  <= ST_MATCH_OVER;
                winner <= WIN_P2;
              end else begin
                state <= ST_INTRO;
              end
            end else begin
              frame_cnt <= frame_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state      <= ST_ATTRACT;
          frame_cnt  <= '0;
          fight_en   <= 1'b0;
          player_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Scenario bench for match_controller with a small frame divider and short
// intro/KO phases; round outcomes flow through an expected-score queue.
module tb_match_controller;

  localparam int FRAME_DIV     = 4;
  localparam int INTRO_FRAMES  = 3;
  localparam int KO_FRAMES     = 2;
  localparam int ROUNDS_TO_WIN = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       p1_died = 1'b0;
  logic       p2_died = 1'b0;
  logic [2:0] p1_buttons_in = 3'd0;
  logic [2:0] p2_buttons_in = 3'd0;
  logic       frame_tick;
  logic [2:0] p1_buttons;
  logic [2:0] p2_buttons;
  logic       player_rst;
  logic [2:0] match_state;
  logic [1:0] p1_wins;
  logic [1:0] p2_wins;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {p1_wins, p2_wins} pushed when a death is driven, popped at KO.
  logic [3:0] exp_q[$];
  logic [1:0] m_p1 = 2'd0;
  logic [1:0] m_p2 = 2'd0;

  match_controller #(
    .FRAME_DIV     (FRAME_DIV),
    .INTRO_FRAMES  (INTRO_FRAMES),
    .KO_FRAMES     (KO_FRAMES),
    .ROUNDS_TO_WIN (ROUNDS_TO_WIN)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .p1_died       (p1_died),
    .p2_died       (p2_died),
    .p1_buttons_in (p1_buttons_in),
    .p2_buttons_in (p2_buttons_in),
    .frame_tick    (frame_tick),
    .p1_buttons    (p1_buttons),
    .p2_buttons    (p2_buttons),
    .player_rst    (player_rst),
    .match_state   (match_state),
    .p1_wins       (p1_wins),
    .p2_wins       (p2_wins),
    .winner        (winner)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] model_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    int cyc;
    reset_n = 1'b0;
    p1_buttons_in = 3'b111;
    p2_buttons_in = 3'b111;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({match_state, player_rst, frame_tick, p1_buttons, p2_buttons, p1_wins, p2_wins, winner}
        !== {3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d rst=%b tick=%b b1=%b b2=%b w1=%0d w2=%0d win=%0d, want 0 1 0 000 000 0 0 0",
               match_state, player_rst, frame_tick, p1_buttons, p2_buttons, p1_wins, p2_wins, winner);
    end
    reset_n = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!frame_tick && cyc < 20);
    n_checks++;
    if (cyc !== 4) begin
      n_fail++;
      $display("FAIL first_tick: got tick after %0d clk, want 4", cyc);
    end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!frame_tick && cyc < 20);
    n_checks++;
    if (cyc !== FRAME_DIV) begin
      n_fail++;
      $display("FAIL tick_period: got %0d clk, want %0d", cyc, FRAME_DIV);
    end
    p1_buttons_in = 3'd0;
    p2_buttons_in = 3'd0;
  endtask

  task automatic press_start(input logic keep_high);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({match_state, player_rst, p1_wins, p2_wins, winner} !== {3'd1, 1'b1, 2'd0, 2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL start_to_intro: state=%0d rst=%b w1=%0d w2=%0d win=%0d, want 1 1 0 0 0",
               match_state, player_rst, p1_wins, p2_wins, winner);
    end
    if (!keep_high) start = 1'b0;
    m_p1 = 2'd0;
    m_p2 = 2'd0;
  endtask

  task automatic run_intro();
    int ticks;
    int cyc;
    logic [2:0] exp_b;
    ticks = 0;
    cyc = 0;
    p1_buttons_in = 3'b111;
    p2_buttons_in = 3'b011;
    #1;
    n_checks++;
    if ({p1_buttons, p2_buttons, player_rst} !== {3'd0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL intro_gate: b1=%b b2=%b rst=%b, want 000 000 1", p1_buttons, p2_buttons, player_rst);
    end
    while (match_state == 3'd1 && cyc < 100) begin
      if (frame_tick) ticks++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (ticks !== INTRO_FRAMES || match_state !== 3'd2 || player_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL intro_len: ticks=%0d state=%0d rst=%b, want %0d 2 0", ticks, match_state, player_rst, INTRO_FRAMES);
    end
    p1_buttons_in = 3'b101;
    exp_b = 3'($urandom_range(0, 7));
    p2_buttons_in = exp_b;
    #1;
    n_checks++;
    if (p1_buttons !== 3'b101 || p2_buttons !== exp_b) begin
      n_fail++;
      $display("FAIL fight_pass: b1=%b b2=%b, want 101 %b", p1_buttons, p2_buttons, exp_b);
    end
  endtask

  task automatic play_round(input logic d1, input logic d2);
    int ticks;
    int cyc;
    logic [3:0] exp_w;
    logic [2:0] exp_state;
    logic [1:0] exp_win;
    ticks = 0;
    cyc = 0;
    repeat ($urandom_range(1, 6)) @(negedge clk);
    n_checks++;
    if (match_state !== 3'd2) begin
      n_fail++;
      $display("FAIL fight_hold: state=%0d, want 2", match_state);
    end
    if (d1 && !d2) m_p2 = model_inc(m_p2);
    if (d2 && !d1) m_p1 = model_inc(m_p1);
    exp_q.push_back({m_p1, m_p2});
    p1_died = d1;
    p2_died = d2;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    n_checks++;
    if (match_state !== 3'd3 || {p1_wins, p2_wins} !== exp_w) begin
      n_fail++;
      $display("FAIL ko_score: state=%0d w1=%0d w2=%0d, want 3 %0d %0d",
               match_state, p1_wins, p2_wins, exp_w[3:2], exp_w[1:0]);
    end
    if (frame_tick) ticks++;
    // Late deaths during KO must not score again.
    p1_died = 1'b1;
    p2_died = 1'b1;
    p1_buttons_in = 3'b111;
    p2_buttons_in = 3'b111;
    #1;
    n_checks++;
    if ({p1_buttons, p2_buttons, player_rst} !== {3'd0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL ko_gate: b1=%b b2=%b rst=%b, want 000 000 0", p1_buttons, p2_buttons, player_rst);
    end
    @(negedge clk);
    p1_died = 1'b0;
    p2_died = 1'b0;
    n_checks++;
    if ({p1_wins, p2_wins} !== exp_w) begin
      n_fail++;
      $display("FAIL ko_late_died: w1=%0d w2=%0d, want %0d %0d", p1_wins, p2_wins, exp_w[3:2], exp_w[1:0]);
    end
    while (match_state == 3'd3 && cyc < 100) begin
      if (frame_tick) ticks++;
      @(negedge clk);
      cyc++;
    end
    exp_state = 3'd1;
    exp_win = 2'd0;
    if (m_p1 == 2'(ROUNDS_TO_WIN)) begin
      exp_state = 3'd4;
      exp_win = 2'd1;
    end else if (m_p2 == 2'(ROUNDS_TO_WIN)) begin
      exp_state = 3'd4;
      exp_win = 2'd2;
    end
    n_checks++;
    if (ticks !== KO_FRAMES || match_state !== exp_state || winner !== exp_win || player_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL ko_exit: ticks=%0d state=%0d win=%0d rst=%b, want %0d %0d %0d 1",
               ticks, match_state, winner, player_rst, KO_FRAMES, exp_state, exp_win);
    end
  endtask

  task automatic test_start_intro();
    press_start(1'b0);
    run_intro();
  endtask

  task automatic test_p2_died();
    play_round(1'b0, 1'b1);
    run_intro();
  endtask

  task automatic test_draw();
    play_round(1'b1, 1'b1);
    run_intro();
  endtask

  task automatic test_match_over();
    play_round(1'b0, 1'b1);
    repeat (6) @(negedge clk);
    n_checks++;
    if ({match_state, p1_wins, p2_wins, winner, player_rst} !== {3'd4, 2'd2, 2'd0, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL match_over_hold: state=%0d w1=%0d w2=%0d win=%0d rst=%b, want 4 2 0 1 1",
               match_state, p1_wins, p2_wins, winner, player_rst);
    end
    press_start(1'b1);
  endtask

  task automatic test_start_ignored();
    run_intro();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = ~start;
      @(negedge clk);
      n_checks++;
      if (match_state !== 3'd2) begin
        n_fail++;
        $display("FAIL start_in_fight: state=%0d, want 2", match_state);
      end
    end
    start = 1'b0;
    play_round(1'b1, 1'b0);
    run_intro();
  endtask

  task automatic test_async_reset();
    int cyc;
    repeat (2) @(negedge clk);
    p2_died = 1'b1;
    @(negedge clk);
    p2_died = 1'b0;
    m_p1 = model_inc(m_p1);
    n_checks++;
    if (match_state !== 3'd3 || p1_wins !== m_p1) begin
      n_fail++;
      $display("FAIL pre_reset_ko: state=%0d w1=%0d, want 3 %0d", match_state, p1_wins, m_p1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({match_state, player_rst, frame_tick, p1_wins, p2_wins, winner}
        !== {3'd0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d rst=%b tick=%b w1=%0d w2=%0d win=%0d, want 0 1 0 0 0 0",
               match_state, player_rst, frame_tick, p1_wins, p2_wins, winner);
    end
    m_p1 = 2'd0;
    m_p2 = 2'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!frame_tick && cyc < 20);
    n_checks++;
    if (cyc !== 4 || match_state !== 3'd0) begin
      n_fail++;
      $display("FAIL tick_after_reset: tick after %0d clk state=%0d, want 4 0", cyc, match_state);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_start_intro();
    test_p2_died();
    test_draw();
    test_match_over();
    test_start_ignored();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
